// File: rtl/mtime_timer_pkg.sv
// -----------------------------------------------------------------------------
// mtime_timer_pkg
// Shared types and helpers for the RISC-V machine timer peripheral.
//   mtimer_reg_req_t : register request (valid, write, addr, wdata, wstrb)
//   mtimer_reg_rsp_t : register response (ready, error, rdata)
//   reg_idx_e        : register index decoded from addr[4:2]
//   apply_wstrb      : byte-lane merge of write data into an old word
// -----------------------------------------------------------------------------
package mtime_timer_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mtimer_reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } mtimer_reg_rsp_t;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESC    = 3'd1,
    REG_MTIME_LO = 3'd2,
    REG_MTIME_HI = 3'd3,
    REG_CMP_LO   = 3'd4,
    REG_CMP_HI   = 3'd5,
    REG_STATUS   = 3'd6,
    REG_NONE     = 3'd7
  } reg_idx_e;

  // Replace only the byte lanes selected by strb; other lanes keep old_val.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtime_timer.sv
// -----------------------------------------------------------------------------
// mtime_timer
// RISC-V machine timer: 64-bit mtime counter advanced by a programmable
// prescaler, 64-bit mtimecmp compare register, level interrupt.
// Ports:
//   clk_i      : sole clock
//   rst_i      : asynchronous active-high reset
//   reg_req_i  : register request (valid/write/addr/wdata/wstrb)
//   reg_rsp_o  : register response (ready always 1, combinational rdata/error)
//   time_irq_o : registered (mtime >= mtimecmp)
// -----------------------------------------------------------------------------
module mtime_timer
  import mtime_timer_pkg::*;
#(
  parameter type reg_req_t = mtime_timer_pkg::mtimer_reg_req_t,
  parameter type reg_rsp_t = mtime_timer_pkg::mtimer_reg_rsp_t,
  parameter int unsigned PrescWidth = 16
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output logic     time_irq_o
);

  logic                  en_reg, en_next;
  logic [PrescWidth-1:0] presc_reg, presc_next;
  logic [PrescWidth-1:0] presc_cnt_reg, presc_cnt_next;
  logic [63:0]           mtime_reg, mtime_next;
  logic [63:0]           mtimecmp_reg, mtimecmp_next;
  logic                  irq_reg;

  reg_idx_e    reg_idx;
  logic        addr_err;
  logic        wr_en;
  logic        tick;
  logic [31:0] rdata;

  // Upper address bits are decoded by the bus fabric, not here.
  logic unused_addr;
  assign unused_addr = ^reg_req_i.addr[31:5];

  assign reg_idx  = reg_idx_e'(reg_req_i.addr[4:2]);
  assign addr_err = (reg_req_i.addr[1:0] != 2'b00) || (reg_idx == REG_NONE);
  assign wr_en    = reg_req_i.valid && reg_req_i.write && !addr_err;
  assign tick     = en_reg && (presc_cnt_reg == presc_reg);

  // Next-state: the counter advance is computed first, then a software write
  // to an mtime word overrides it. Both halves of an mtime write merge against
  // the pre-edge value, so a coincident tick (and its carry) is lost.
  always_comb begin
    en_next        = en_reg;
    presc_next     = presc_reg;
    presc_cnt_next = presc_cnt_reg;
    mtime_next     = mtime_reg;
    mtimecmp_next  = mtimecmp_reg;

    if (en_reg) begin
      if (tick) begin
        presc_cnt_next = '0;
        mtime_next     = mtime_reg + 64'd1;
      end else begin
        presc_cnt_next = presc_cnt_reg + PrescWidth'(1);
      end
    end

    if (wr_en) begin
      case (reg_idx)
        REG_CTRL: begin
          if (reg_req_i.wstrb[0]) en_next = reg_req_i.wdata[0];
          if (!en_next) presc_cnt_next = '0;
        end
        REG_PRESC: begin
          presc_next     = PrescWidth'(apply_wstrb(32'(presc_reg), reg_req_i.wdata,
                                                   reg_req_i.wstrb));
          presc_cnt_next = '0;
        end
        REG_MTIME_LO: mtime_next = {mtime_reg[63:32],
                                    apply_wstrb(mtime_reg[31:0], reg_req_i.wdata,
                                                reg_req_i.wstrb)};
        REG_MTIME_HI: mtime_next = {apply_wstrb(mtime_reg[63:32], reg_req_i.wdata,
                                                reg_req_i.wstrb),
                                    mtime_reg[31:0]};
        REG_CMP_LO: mtimecmp_next = {mtimecmp_reg[63:32],
                                     apply_wstrb(mtimecmp_reg[31:0], reg_req_i.wdata,
                                                 reg_req_i.wstrb)};
        REG_CMP_HI: mtimecmp_next = {apply_wstrb(mtimecmp_reg[63:32], reg_req_i.wdata,
                                                 reg_req_i.wstrb),
                                     mtimecmp_reg[31:0]};
        default: ;  // STATUS is read-only; writes are silently dropped
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_reg        <= 1'b0;
      presc_reg     <= '0;
      presc_cnt_reg <= '0;
      mtime_reg     <= '0;
      mtimecmp_reg  <= '1;
      irq_reg       <= 1'b0;
    end else begin
      en_reg        <= en_next;
      presc_reg     <= presc_next;
      presc_cnt_reg <= presc_cnt_next;
      mtime_reg     <= mtime_next;
      mtimecmp_reg  <= mtimecmp_next;
      // Compare uses the current-cycle values, so the irq trails the state by one edge.
      irq_reg       <= (mtime_reg >= mtimecmp_reg);
    end
  end

  // Read data is driven only for valid, well-addressed reads; otherwise zero.
  always_comb begin
    rdata = '0;
    if (reg_req_i.valid && !reg_req_i.write && !addr_err) begin
      case (reg_idx)
        REG_CTRL:     rdata = {31'd0, en_reg};
        REG_PRESC:    rdata = 32'(presc_reg);
        REG_MTIME_LO: rdata = mtime_reg[31:0];
        REG_MTIME_HI: rdata = mtime_reg[63:32];
        REG_CMP_LO:   rdata = mtimecmp_reg[31:0];
        REG_CMP_HI:   rdata = mtimecmp_reg[63:32];
        REG_STATUS:   rdata = {31'd0, irq_reg};
        default:      rdata = '0;
      endcase
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = reg_req_i.valid && addr_err;
    reg_rsp_o.rdata = rdata;
  end

  assign time_irq_o = irq_reg;

endmodule

// File: tb/tb_mtime_timer.sv
// -----------------------------------------------------------------------------
// tb_mtime_timer
// Table-driven and randomized checks of mtime_timer against a behavioural
// model of the timer's register rules.
// -----------------------------------------------------------------------------
module tb_mtime_timer;
  import mtime_timer_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  mtimer_reg_req_t req;
  mtimer_reg_rsp_t rsp;
  logic            irq;

  int errors = 0;
  int checks = 0;

  // values sampled in the most recent cycle
  logic [31:0] s_rd;
  logic        s_er;
  logic        s_irq;

  mtime_timer #(
    .reg_req_t (mtimer_reg_req_t),
    .reg_rsp_t (mtimer_reg_rsp_t),
    .PrescWidth(16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .time_irq_o(irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit        m_en;
  bit [15:0] m_presc;
  bit [15:0] m_phase;   // enabled cycles since the last tick
  bit [63:0] m_mtime;
  bit [63:0] m_cmp;
  bit        m_irq;

  function automatic void model_reset();
    m_en = 0; m_presc = 0; m_phase = 0; m_mtime = 0; m_cmp = '1; m_irq = 0;
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[4:2] == 3'd7);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (bad_addr(a)) return 32'd0;
    case (a[4:2])
      3'd0: return {31'd0, m_en};
      3'd1: return {16'd0, m_presc};
      3'd2: return m_mtime[31:0];
      3'd3: return m_mtime[63:32];
      3'd4: return m_cmp[31:0];
      3'd5: return m_cmp[63:32];
      default: return {31'd0, m_irq};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic void model_step(input logic v, input logic w, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] s);
    bit [63:0] pre;
    bit        irq_n;
    logic [31:0] p32;
    pre   = m_mtime;
    irq_n = (m_mtime >= m_cmp);
    if (m_en) begin
      if (m_phase == m_presc) begin
        m_phase = 0;
        m_mtime = m_mtime + 64'd1;
      end else begin
        m_phase = m_phase + 16'd1;
      end
    end
    if (v && w && !bad_addr(a)) begin
      case (a[4:2])
        3'd0: begin
          if (s[0]) m_en = d[0];
          if (!m_en) m_phase = 0;
        end
        3'd1: begin
          p32 = merge({16'd0, m_presc}, d, s);
          m_presc = p32[15:0];
          m_phase = 0;
        end
        3'd2: m_mtime = {pre[63:32], merge(pre[31:0], d, s)};
        3'd3: m_mtime = {merge(pre[63:32], d, s), pre[31:0]};
        3'd4: m_cmp = {m_cmp[63:32], merge(m_cmp[31:0], d, s)};
        3'd5: m_cmp = {merge(m_cmp[63:32], d, s), m_cmp[31:0]};
        default: ;
      endcase
    end
    m_irq = irq_n;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle; called just after a rising edge, returns just after the next.
  task automatic do_cycle(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    req.valid = v; req.write = w; req.addr = a; req.wdata = d; req.wstrb = s;
    @(negedge clk);
    s_rd = rsp.rdata; s_er = rsp.error; s_irq = irq;
    check("irq_model", {63'd0, s_irq}, {63'd0, m_irq});
    if (v) begin
      check("ready", {63'd0, rsp.ready}, 64'd1);
      check("err_model", {63'd0, s_er}, {63'd0, bad_addr(a)});
      if (!w) check("rdata_model", {32'd0, s_rd}, {32'd0, model_read(a)});
      $display("txn t=%0t %s addr=%h wdata=%h strb=%h rdata=%h err=%0d irq=%0d",
               $time, w ? "WR" : "RD", a, d, s, s_rd, s_er, s_irq);
    end
    model_step(v, w, a, d, s);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    do_cycle(1'b1, 1'b1, a, d, 4'hF);
  endtask

  task automatic rd(input logic [31:0] a);
    do_cycle(1'b1, 1'b0, a, 32'd0, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;

  vec_t reset_tab[7];
  vec_t acc_tab[17];

  task automatic run_tab(input string name, input vec_t t[], input int n);
    for (int i = 0; i < n; i++) begin
      do_cycle(1'b1, t[i].w, t[i].a, t[i].d, t[i].s);
      check($sformatf("%s[%0d].err", name, i), {63'd0, s_er}, {63'd0, t[i].exp_er});
      if (!t[i].w)
        check($sformatf("%s[%0d].rd", name, i), {32'd0, s_rd}, {32'd0, t[i].exp_rd});
    end
  endtask

  initial begin
    reset_tab[0] = '{0, 32'h00, 0, 0, 32'h0, 0};
    reset_tab[1] = '{0, 32'h04, 0, 0, 32'h0, 0};
    reset_tab[2] = '{0, 32'h08, 0, 0, 32'h0, 0};
    reset_tab[3] = '{0, 32'h0C, 0, 0, 32'h0, 0};
    reset_tab[4] = '{0, 32'h10, 0, 0, 32'hFFFFFFFF, 0};
    reset_tab[5] = '{0, 32'h14, 0, 0, 32'hFFFFFFFF, 0};
    reset_tab[6] = '{0, 32'h18, 0, 0, 32'h0, 0};

    acc_tab[0]  = '{1, 32'h00, 32'h0,        4'hF, 0, 0};
    acc_tab[1]  = '{1, 32'h08, 32'h100,      4'hF, 0, 0};
    acc_tab[2]  = '{1, 32'h0C, 32'h2,        4'hF, 0, 0};
    acc_tab[3]  = '{1, 32'h14, 32'h0,        4'hF, 0, 0};
    acc_tab[4]  = '{1, 32'h10, 32'h12345678, 4'hF, 0, 0};
    acc_tab[5]  = '{1, 32'h10, 32'hDEADBEAB, 4'h1, 0, 0};
    acc_tab[6]  = '{1, 32'h1C, 32'hFFFFFFFF, 4'hF, 0, 1};
    acc_tab[7]  = '{1, 32'h0A, 32'h0000DEAD, 4'hF, 0, 1};
    acc_tab[8]  = '{1, 32'h18, 32'h0,        4'hF, 0, 0};
    acc_tab[9]  = '{0, 32'h1C, 0, 0, 32'h0, 1};
    acc_tab[10] = '{0, 32'h09, 0, 0, 32'h0, 1};
    acc_tab[11] = '{0, 32'h08, 0, 0, 32'h100, 0};
    acc_tab[12] = '{0, 32'hFFFFFF0C, 0, 0, 32'h2, 0};
    acc_tab[13] = '{0, 32'h10, 0, 0, 32'h123456AB, 0};
    acc_tab[14] = '{0, 32'h14, 0, 0, 32'h0, 0};
    acc_tab[15] = '{0, 32'h00, 0, 0, 32'h0, 0};
    acc_tab[16] = '{0, 32'h18, 0, 0, 32'h1, 0};

    req = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset values
    run_tab("reset", reset_tab, 7);

    // prescaler: PRESC=3 gives a tick every 4 enabled cycles
    wr(32'h04, 32'd3);
    wr(32'h00, 32'd1);
    idle(40);
    rd(32'h08);
    check("presc3_mtime", {32'd0, s_rd}, 64'd10);

    // carry from LO into HI
    wr(32'h00, 32'd0);
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'hFFFFFFFE);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'd1);
    idle(1);
    wr(32'h00, 32'd0);
    rd(32'h08); check("carry_lo", {32'd0, s_rd}, 64'd0);
    rd(32'h0C); check("carry_hi", {32'd0, s_rd}, 64'd1);

    // full 64-bit wrap
    wr(32'h0C, 32'hFFFFFFFF);
    wr(32'h08, 32'hFFFFFFFF);
    wr(32'h00, 32'd1);
    wr(32'h00, 32'd0);
    rd(32'h08); check("wrap_lo", {32'd0, s_rd}, 64'd0);
    rd(32'h0C); check("wrap_hi", {32'd0, s_rd}, 64'd0);

    // interrupt rise at mtime==0x20 and fall after a compare write
    begin
      bit seen_rise;
      seen_rise = 0;
      wr(32'h14, 32'd0);
      wr(32'h10, 32'h20);
      wr(32'h00, 32'd1);
      for (int i = 0; i < 80 && !seen_rise; i++) begin
        rd(32'h08);
        if (s_rd == 32'h20) check("irq_before_rise", {63'd0, s_irq}, 64'd0);
        if (s_rd == 32'h21) begin
          check("irq_rise", {63'd0, s_irq}, 64'd1);
          seen_rise = 1;
        end
      end
      if (!seen_rise) begin
        errors++;
        checks++;
        $display("FAIL irq_rise_timeout: got no rise expected rise within 80 cycles");
      end
      wr(32'h10, 32'h1000);
      check("irq_hold_wr", {63'd0, s_irq}, 64'd1);
      idle(1);
      check("irq_hold_next", {63'd0, s_irq}, 64'd1);
      idle(1);
      check("irq_fall", {63'd0, s_irq}, 64'd0);
      wr(32'h00, 32'd0);
    end

    // software write wins over a coincident tick
    wr(32'h00, 32'd1);
    wr(32'h08, 32'h55);
    rd(32'h08); check("wr_wins_lo", {32'd0, s_rd}, 64'h55);
    wr(32'h00, 32'd0);
    wr(32'h08, 32'hFFFFFFFF);
    wr(32'h0C, 32'd5);
    wr(32'h00, 32'd1);
    wr(32'h0C, 32'd7);
    wr(32'h00, 32'd0);
    rd(32'h0C); check("wr_wins_hi", {32'd0, s_rd}, 64'd8);
    rd(32'h08); check("wr_wins_lo_kept", {32'd0, s_rd}, 64'd0);

    // byte strobes, address errors, STATUS write
    run_tab("access", acc_tab, 17);

    // randomized traffic
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd0);
    wr(32'h14, 32'd0);
    wr(32'h10, 32'd150);
    for (int n = 0; n < 500; n++) begin
      logic        v, w;
      logic [2:0]  idx;
      logic [31:0] a, d;
      logic [3:0]  s;
      v   = ($urandom_range(0, 2) != 0);
      w   = ($urandom_range(0, 1) != 0);
      idx = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      a[4:2] = idx;
      a[1:0] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (idx)
        3'd0: d = ($urandom_range(0, 4) != 0) ? 32'd1 : 32'd0;
        3'd1: d = 32'($urandom_range(0, 5));
        3'd2, 3'd4: d = 32'($urandom_range(0, 400));
        3'd3, 3'd5: d = ($urandom_range(0, 3) != 0) ? 32'd0 : $urandom;
        default: ;
      endcase
      do_cycle(v, w, a, d, s);
    end

    // asynchronous reset mid-operation
    wr(32'h14, 32'd0);
    wr(32'h10, 32'd0);
    wr(32'h04, 32'd1);
    wr(32'h00, 32'd1);
    idle(3);
    check("irq_before_reset", {63'd0, s_irq}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("irq_async_reset", {63'd0, irq}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_tab("reset2", reset_tab, 7);

    // first tick after release: enable, then PRESC+1 cycles
    wr(32'h04, 32'd2);
    wr(32'h00, 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd(32'h08);
      check($sformatf("first_tick[%0d]", i), {32'd0, s_rd}, (i >= 3) ? 64'd1 : 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
